bomberman_axil_reg_slave: RTL and testbench
===========================================

Name: bomberman_axil_reg_slave

Overview:
- AXI4-Lite slave (responder) exposing a bank of 32-bit registers to the PS/VIP master.
- Game logic reads the same bank through a side read port.
- Also pulses a per-register update strobe on every committed write.
- Sits between the AXI interconnect and the bomberman map/state logic.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width in bits; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; the word index is addr[ADDR_WIDTH-1:2].
- NUM_REGS, 16, number of implemented registers, 1..2^(ADDR_WIDTH-2).

Ports:
- ACLK  in  1  single clock.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- usr_raddr  in  clog2(NUM_REGS)  game-side register index.
- usr_rdata  out  32  game-side read data, registered.
- reg_wr_pulse  out  NUM_REGS  one-hot strobe, one cycle per committed write.

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - All registers = 0.
  - AWREADY=WREADY=ARREADY=0; BVALID=RVALID=0; BRESP=RRESP=00; RDATA=0; usr_rdata=0; reg_wr_pulse=0.
  - Both FSMs return to IDLE.
  - Reset mid-transaction abandons it with no register update.
- First cycle after reset release: AWREADY=WREADY=ARREADY=1.
- Write FSM states are W_IDLE, W_HAVE_AW, W_HAVE_W and W_RESP.
  - AWREADY=1 in W_IDLE or W_HAVE_W. WREADY=1 in W_IDLE or W_HAVE_AW. Both are registered outputs.
  - W_IDLE + AW and W handshakes in the same cycle -> commit -> W_RESP.
  - W_IDLE + AW handshake only -> W_HAVE_AW, address latched. W_IDLE + W handshake only -> W_HAVE_W, data and strobe latched.
  - W_HAVE_AW + W handshake -> commit -> W_RESP. W_HAVE_W + AW handshake -> commit -> W_RESP.
  - Commit: for each strobe bit set, write the corresponding byte. reg_wr_pulse[idx]=1 for exactly the following cycle. BVALID=1 on the cycle after commit.
  - Index >= NUM_REGS: no register write, no pulse, BRESP=10 (SLVERR). Otherwise BRESP=00.
  - WSTRB=0 on a valid index: no bytes change, pulse still issued, BRESP=00.
  - W_RESP: BVALID held with BRESP stable until BREADY=1, then W_IDLE with BVALID=0. AWREADY/WREADY return to 1 on the following cycle.
  - At most one outstanding write.
- Read FSM states are R_IDLE and R_DATA.
  - ARREADY=1 only in R_IDLE.
  - AR handshake -> R_DATA. Next cycle RVALID=1 with RDATA = register content at the handshake edge. Read latency is 1 cycle from the AR handshake.
  - Index >= NUM_REGS: RDATA=0, RRESP=10. Otherwise RRESP=00.
  - RVALID, RDATA and RRESP are held stable until RREADY=1, then R_IDLE with RVALID=0 and ARREADY=1.
- Simultaneous events:
  - Read and write channels are fully independent and may complete in the same cycle.
  - AR handshake in the same cycle as a write commit to the same index returns the OLD value.
  - usr_rdata = reg[usr_raddr] sampled each cycle (1-cycle latency). It shows new data the cycle after commit.
  - usr_raddr >= NUM_REGS gives usr_rdata = 0.
- Address low bits [1:0] are ignored; no unaligned access. PROT inputs are ignored.

Test Plan:
- Four sequential writes of 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC (WSTRB=F), then four reads -> BRESP=00 each; reads return 0x1..0x4 with RRESP=00; reg_wr_pulse bits 0..3 pulse once each.
- WVALID asserted 3 cycles before AWVALID (addr 0x10, data 0xDEADBEEF) -> WREADY drops after the W handshake, the write commits only after AW, BVALID follows; read of 0x10 returns 0xDEADBEEF.
- Reg 0 = 0xAABBCCDD, then write 0x11223344 to 0x0 with WSTRB=0101 -> read returns 0xAA22CC44.
- Write and read to address 0x3C when NUM_REGS=8 -> BRESP=10, RRESP=10, RDATA=0, no reg_wr_pulse.
- BREADY and RREADY held low for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stay stable; AWREADY/WREADY/ARREADY stay 0 until each response handshakes.
- ARESETN pulled low while in W_HAVE_AW with reg 2 = 0x55 -> all outputs reset at once; reg 2 reads 0 after reset; the next write of 0x7 to 0x8 completes normally.

Source files
------------

// File: rtl/bomberman_axil_reg_slave.sv
// AXI4-Lite register bank shared with the bomberman game logic: AXI read/write
// access, a registered game-side read port and a one-hot per-register write strobe.
module bomberman_axil_reg_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned NUM_REGS           = 16,
    localparam int unsigned RIDX_W            = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [RIDX_W-1:0]                 usr_raddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     usr_rdata,
    output logic [NUM_REGS-1:0]               reg_wr_pulse
);

    localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t          wstate;
    rstate_t          rstate;
    logic [DW-1:0]    regs [NUM_REGS];
    logic [IDX_W-1:0] aw_idx_q;
    logic [DW-1:0]    wdata_q;
    logic [SW-1:0]    wstrb_q;

    logic             aw_hs_c, w_hs_c, ar_hs_c, commit_c, wr_ok_c, rd_ok_c, usr_ok_c;
    logic [IDX_W-1:0] wr_idx_c, rd_idx_c;
    logic [DW-1:0]    wr_data_c;
    logic [SW-1:0]    wr_strb_c;
    logic             unused_c;

    assign aw_hs_c  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs_c   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs_c  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign rd_idx_c = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_ok_c  = 32'(rd_idx_c) < NUM_REGS;
    assign usr_ok_c = 32'(usr_raddr) < NUM_REGS;
    assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Commit happens when the second half of the AW/W pair arrives; pick live or latched halves.
    always_comb begin
        commit_c  = 1'b0;
        wr_idx_c  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        wr_data_c = S_AXI_WDATA;
        wr_strb_c = S_AXI_WSTRB;
        case (wstate)
            W_IDLE:    commit_c = aw_hs_c & w_hs_c;
            W_HAVE_AW: begin
                commit_c = w_hs_c;
                wr_idx_c = aw_idx_q;
            end
            W_HAVE_W:  begin
                commit_c  = aw_hs_c;
                wr_data_c = wdata_q;
                wr_strb_c = wstrb_q;
            end
            default:   commit_c = 1'b0;
        endcase
        wr_ok_c = 32'(wr_idx_c) < NUM_REGS;
    end

    // Write channel FSM with registered handshake outputs and update strobe.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate        <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            reg_wr_pulse  <= '0;
        end else begin
            reg_wr_pulse <= '0;
            case (wstate)
                W_IDLE: begin
                    S_AXI_AWREADY <= 1'b1;
                    S_AXI_WREADY  <= 1'b1;
                    if (!commit_c && aw_hs_c) begin
                        aw_idx_q      <= wr_idx_c;
                        S_AXI_AWREADY <= 1'b0;
                        wstate        <= W_HAVE_AW;
                    end else if (!commit_c && w_hs_c) begin
                        wdata_q      <= S_AXI_WDATA;
                        wstrb_q      <= S_AXI_WSTRB;
                        S_AXI_WREADY <= 1'b0;
                        wstate       <= W_HAVE_W;
                    end
                end
                W_HAVE_AW, W_HAVE_W: ;
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        wstate        <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
            if (commit_c) begin
                S_AXI_AWREADY <= 1'b0;
                S_AXI_WREADY  <= 1'b0;
                S_AXI_BVALID  <= 1'b1;
                S_AXI_BRESP   <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
                wstate        <= W_RESP;
                if (wr_ok_c) begin
                    reg_wr_pulse <= NUM_REGS'(1) << RIDX_W'(wr_idx_c);
                end
            end
        end
    end

    // Register bank: byte-enabled update on an in-range commit.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs <= '{default: '0};
        end else if (commit_c && wr_ok_c) begin
            for (int b = 0; b < int'(SW); b++) begin
                if (wr_strb_c[b]) begin
                    regs[RIDX_W'(wr_idx_c)][8*b +: 8] <= wr_data_c[8*b +: 8];
                end
            end
        end
    end

    // Read channel FSM; data is captured at the AR handshake edge, so a same-edge write is not seen.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rstate        <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (ar_hs_c) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RDATA   <= rd_ok_c ? regs[RIDX_W'(rd_idx_c)] : '0;
                        S_AXI_RRESP   <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
                        rstate        <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        rstate        <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // Game-side port: one-cycle registered lookup.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            usr_rdata <= '0;
        end else begin
            usr_rdata <= usr_ok_c ? regs[usr_raddr] : '0;
        end
    end

endmodule

// File: tb/tb_bomberman_axil_reg_slave.sv
// Randomized scoreboard bench for bomberman_axil_reg_slave (12-register build so
// out-of-range indices exist on both the AXI and game-side ports).
module tb_bomberman_axil_reg_slave;

    localparam int unsigned AW    = 6;
    localparam int unsigned NREGS = 12;
    localparam int unsigned RIW   = 4;
    localparam int          TMO   = 50;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    awaddr, araddr;
    logic [2:0]       awprot, arprot;
    logic             awvalid, awready, wvalid, wready, bvalid, bready;
    logic             arvalid, arready, rvalid, rready;
    logic [31:0]      wdata, rdata, usr_rdata;
    logic [3:0]       wstrb;
    logic [1:0]       bresp, rresp;
    logic [RIW-1:0]   usr_raddr;
    logic [NREGS-1:0] reg_wr_pulse;

    bomberman_axil_reg_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NREGS)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .usr_raddr(usr_raddr), .usr_rdata(usr_rdata), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0]      model [16];
    logic [1:0]       exp_b [$];
    logic [33:0]      exp_r [$];
    logic [NREGS-1:0] exp_p [$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops the scoreboard on every response handshake and checks channel rules.
    logic hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic aw_acc, w_acc, ar_acc, commit_pend, b_done, r_done, ar_new, b_stall, r_stall;
    logic [1:0]  b_prev_resp, r_prev_resp;
    logic [31:0] r_prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            {aw_acc, w_acc, ar_acc, commit_pend, b_done, r_done, ar_new, b_stall, r_stall} = '0;
        end else begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_b  = bvalid && bready;
            hs_ar = arvalid && arready;
            hs_r  = rvalid && rready;
            if (aw_acc)  check("awready_low_while_outstanding", 64'(awready), 64'd0);
            if (w_acc)   check("wready_low_while_outstanding", 64'(wready), 64'd0);
            if (ar_acc)  check("arready_low_while_outstanding", 64'(arready), 64'd0);
            if (b_done)  check("aw_w_ready_after_b", 64'({awready, wready}), 64'd3);
            if (r_done)  check("arready_after_r", 64'(arready), 64'd1);
            if (ar_new)  check("read_latency_rvalid", 64'(rvalid), 64'd1);
            if (b_stall) check("b_stable_under_stall", 64'({bvalid, bresp}), 64'({1'b1, b_prev_resp}));
            if (r_stall) check("r_stable_under_stall", 64'({rvalid, rresp, rdata}),
                               64'({1'b1, r_prev_resp, r_prev_data}));
            if (commit_pend) begin
                check("bvalid_after_commit", 64'(bvalid), 64'd1);
                if (exp_p.size() == 0) check("wr_pulse_unexpected_commit", 64'(reg_wr_pulse), 64'd0);
                else check("wr_pulse", 64'(reg_wr_pulse), 64'(exp_p.pop_front()));
            end else if (reg_wr_pulse != '0) begin
                check("wr_pulse_spurious", 64'(reg_wr_pulse), 64'd0);
            end
            if (hs_b) begin
                if (exp_b.size() == 0) check("bresp_unexpected", 64'(bresp), 64'hFF);
                else check("bresp", 64'(bresp), 64'(exp_b.pop_front()));
            end
            if (hs_r) begin
                if (exp_r.size() == 0) check("rdata_unexpected", 64'({rresp, rdata}), 64'hFF_FFFF_FFFF);
                else check("rresp_rdata", 64'({rresp, rdata}), 64'(exp_r.pop_front()));
            end
            commit_pend = !(aw_acc && w_acc) && (aw_acc || hs_aw) && (w_acc || hs_w);
            aw_acc      = (aw_acc || hs_aw) && !hs_b;
            w_acc       = (w_acc || hs_w) && !hs_b;
            ar_acc      = (ar_acc || hs_ar) && !hs_r;
            ar_new      = hs_ar;
            b_done      = hs_b;
            r_done      = hs_r;
            b_stall     = bvalid && !bready;
            r_stall     = rvalid && !rready;
            b_prev_resp = bresp;
            r_prev_resp = rresp;
            r_prev_data = rdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) at negedge for a ready/valid, then steps past the handshake edge.
    task automatic wait_cond(input int which, input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((which == 0 && awready) || (which == 1 && wready) || (which == 2 && arready) ||
                (which == 3 && bvalid) || (which == 4 && rvalid)) break;
            n++;
            if (n >= TMO) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout_%s: waited %0d cycles, required handshake", name, n);
                break;
            end
        end
        tick();
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        int idx = int'(addr[AW-1:2]);
        if (idx < int'(NREGS)) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            exp_b.push_back(2'b00);
            exp_p.push_back(NREGS'(1) << idx);
        end else begin
            exp_b.push_back(2'b10);
            exp_p.push_back('0);
        end
        fork
            begin
                repeat (aw_dly) tick();
                awaddr  = addr;
                awvalid = 1'b1;
                wait_cond(0, "awready");
                awvalid = 1'b0;
            end
            begin
                repeat (w_dly) tick();
                wdata  = data;
                wstrb  = strb;
                wvalid = 1'b1;
                wait_cond(1, "wready");
                wvalid = 1'b0;
            end
        join
        repeat (b_dly) tick();
        bready = 1'b1;
        wait_cond(3, "bvalid");
        bready = 1'b0;
    endtask

    task automatic axi_read_exp(input logic [AW-1:0] addr, input logic [33:0] e, input int ar_dly, input int r_dly);
        exp_r.push_back(e);
        repeat (ar_dly) tick();
        araddr  = addr;
        arvalid = 1'b1;
        wait_cond(2, "arready");
        arvalid = 1'b0;
        repeat (r_dly) tick();
        rready = 1'b1;
        wait_cond(4, "rvalid");
        rready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly);
        int idx = int'(addr[AW-1:2]);
        axi_read_exp(addr, (idx < int'(NREGS)) ? {2'b00, model[idx]} : {2'b10, 32'h0}, ar_dly, r_dly);
    endtask

    task automatic check_usr(input logic [RIW-1:0] a);
        usr_raddr = a;
        tick();
        tick();
        check("usr_rdata", 64'(usr_rdata), 64'((32'(a) < NREGS) ? model[a] : 32'h0));
    endtask

    task automatic check_all_reset(input string name);
        check({name, "_ready"}, 64'({awready, wready, arready}), 64'd0);
        check({name, "_valid_resp"}, 64'({bvalid, rvalid, bresp, rresp}), 64'd0);
        check({name, "_rdata"}, 64'(rdata), 64'd0);
        check({name, "_usr_pulse"}, 64'({usr_rdata, reg_wr_pulse}), 64'd0);
    endtask

    initial begin
        logic [33:0] e;
        rst_n = 1'b0;
        {awaddr, araddr, awprot, arprot, awvalid, wvalid, bready, arvalid, rready} = '0;
        wdata = '0; wstrb = '0; usr_raddr = '0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_reset("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("ready_after_reset_release", 64'({awready, wready, arready}), 64'd7);

        // Sequential writes then reads of the first four registers.
        for (int i = 0; i < 4; i++) axi_write(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(AW'(4 * i), 0, 0);

        // Data arrives three cycles ahead of the address.
        axi_write(6'h10, 32'hDEADBEEF, 4'hF, 3, 0, 0);
        axi_read(6'h10, 0, 0);

        // Partial-strobe merge.
        axi_write(6'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        axi_write(6'h00, 32'h11223344, 4'b0101, 0, 0, 0);
        axi_read(6'h00, 0, 0);

        // Out-of-range and boundary indices; low address bits ignored.
        axi_write(6'h3C, 32'h12345678, 4'hF, 0, 1, 0);
        axi_read(6'h3C, 0, 0);
        axi_write(6'h30, 32'hCAFEF00D, 4'hF, 1, 0, 0);
        axi_read(6'h30, 0, 0);
        axi_write(6'h2F, 32'h0BADF00D, 4'hF, 0, 0, 0);
        axi_read(6'h2D, 0, 0);
        axi_write(6'h2C, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
        axi_read(6'h2C, 0, 0);
        check_usr(4'd11);
        check_usr(4'd15);

        // Back-pressure on both response channels at once.
        fork
            axi_write(6'h14, 32'h5A5A0001, 4'hF, 0, 0, 5);
            axi_read(6'h0C, 0, 5);
        join

        // Same-edge read and write of one register returns the old value.
        e = {2'b00, model[5]};
        fork
            axi_write(6'h14, 32'h77778888, 4'hF, 0, 0, 0);
            axi_read_exp(6'h14, e, 0, 0);
        join
        axi_read(6'h14, 0, 0);

        // Reset while holding a write address with no data.
        axi_write(6'h08, 32'h00000055, 4'hF, 0, 0, 0);
        check_usr(4'd2);
        awaddr  = 6'h08;
        awvalid = 1'b1;
        wait_cond(0, "awready_before_reset");
        awvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_reset("async_reset");
        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        axi_read(6'h08, 0, 0);
        axi_write(6'h08, 32'h00000007, 4'hF, 0, 0, 0);
        axi_read(6'h08, 0, 0);
        check_usr(4'd2);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 2))
                0: axi_write(AW'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
                             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
                1: axi_read(AW'($urandom_range(0, 63)), $urandom_range(0, 3), $urandom_range(0, 4));
                default: check_usr(RIW'($urandom_range(0, 15)));
            endcase
        end

        repeat (3) tick();
        check("scoreboard_b_drained", 64'(exp_b.size()), 64'd0);
        check("scoreboard_r_drained", 64'(exp_r.size()), 64'd0);
        check("scoreboard_pulse_drained", 64'(exp_p.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1, "watchdog");
    end

endmodule
